// File: rtl/icache_line_responder_pkg.sv
// ----------------------------------------------------------------------------
// icache_line_responder_pkg
// Shared types and constants for the icache line-fill responder.
//   resp_state_e   : responder FSM states
//   WORD_BITS      : width of one backing-memory word
//   BYTE_OFFSET_BITS : byte-offset bits inside a word
//   line_off_bits(): word-index width inside a line
// ----------------------------------------------------------------------------
package icache_line_responder_pkg;

    localparam int WORD_BITS        = 32;
    localparam int BYTE_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_RESP  = 2'd3
    } resp_state_e;

    function automatic int line_off_bits(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

endpackage

// File: rtl/icache_line_responder_if.sv
// ----------------------------------------------------------------------------
// icache_line_responder_if
// Bundles the cache-side line request handshake and the word-wide backing
// memory port of the responder.
//   master : cache / memory side (drives request and backing read data)
//   slave  : responder side (drives ready, line data and backing reads)
// ----------------------------------------------------------------------------
interface icache_line_responder_if #(
    parameter int NUM_BLOCKS     = 4,
    parameter int BMEM_ADDR_BITS = 16
);
    localparam int LINE_BITS = icache_line_responder_pkg::WORD_BITS * NUM_BLOCKS;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [31:0]               mem_req_addr;
    logic [LINE_BITS-1:0]      mem_req_rdata;
    logic                      bmem_en;
    logic [BMEM_ADDR_BITS-1:0] bmem_addr;
    logic [31:0]               bmem_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, bmem_rdata,
        input  mem_req_ready, mem_req_rdata, bmem_en, bmem_addr
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, bmem_rdata,
        output mem_req_ready, mem_req_rdata, bmem_en, bmem_addr
    );

endinterface

// File: rtl/icache_line_responder_line_fill_buffer.sv
// ----------------------------------------------------------------------------
// icache_line_responder_line_fill_buffer
// Wide line register; one word slot is written per capture strobe.
//   clk, reset : clock, synchronous active-high reset (clears the line)
//   cap_en     : write cap_data into slot cap_idx at the next edge
//   cap_idx    : word slot index
//   cap_data   : 32-bit word
//   line       : assembled line, slot k at [k*32 +: 32]
// ----------------------------------------------------------------------------
module icache_line_responder_line_fill_buffer
    import icache_line_responder_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    localparam int IDX_W     = line_off_bits(NUM_BLOCKS),
    localparam int LINE_BITS = WORD_BITS * NUM_BLOCKS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cap_en,
    input  logic [IDX_W-1:0]     cap_idx,
    input  logic [WORD_BITS-1:0] cap_data,
    output logic [LINE_BITS-1:0] line
);

    logic [LINE_BITS-1:0] line_d, line_q;

    always_comb begin
        line_d = line_q;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (cap_en && (cap_idx == k[IDX_W-1:0])) begin
                line_d[k*WORD_BITS +: WORD_BITS] = cap_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) line_q <= '0;
        else       line_q <= line_d;
    end

    assign line = line_q;

endmodule

// File: rtl/icache_line_responder.sv
// ----------------------------------------------------------------------------
// icache_line_responder
// Memory-side responder for icache line fills. A request waits LATENCY
// cycles, reads NUM_BLOCKS consecutive words from the backing memory and
// returns the assembled line with a one-cycle ready pulse.
//   clk, reset : clock, synchronous active-high reset
//   bus        : icache_line_responder_if.slave (request + backing port)
//   stat_fills, stat_aborts : saturating event counters, present only when
//                ICACHE_RESP_STATS_EN is defined
//
// state    | meaning
// ST_IDLE  | waiting for a request; base address latched on valid
// ST_WAIT  | latency countdown before the first backing read
// ST_FETCH | issuing backing reads, then the final word capture
// ST_RESP  | ready pulse, line complete; always back to idle
// ----------------------------------------------------------------------------
module icache_line_responder
    import icache_line_responder_pkg::*;
#(
    parameter int BLOCK_SIZE     = 4,
    parameter int NUM_BLOCKS     = 4,
    parameter int LATENCY        = 2,
    parameter int BMEM_ADDR_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    icache_line_responder_if.slave bus
`ifdef ICACHE_RESP_STATS_EN
    ,
    output logic [31:0] stat_fills,
    output logic [31:0] stat_aborts
`endif
);

    localparam int LINE_BITS = 8 * BLOCK_SIZE * NUM_BLOCKS;
    localparam int IDX_W     = line_off_bits(NUM_BLOCKS);
    localparam int OFF_BITS  = IDX_W + BYTE_OFFSET_BITS;
    localparam int LAT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [BMEM_ADDR_BITS-1:0] OFF_MASK = BMEM_ADDR_BITS'((1 << OFF_BITS) - 1);

    resp_state_e               state_d, state_q;
    logic [BMEM_ADDR_BITS-1:0] base_d, base_q;
    logic [BMEM_ADDR_BITS-1:0] bmem_addr_d, bmem_addr_q;
    logic                      bmem_en_d, bmem_en_q;
    logic                      ready_d, ready_q;
    logic [LAT_W-1:0]          lat_cnt_d, lat_cnt_q;
    logic [IDX_W-1:0]          blk_d, blk_q;
    logic                      cap_en_d, cap_en_q;
    logic [IDX_W-1:0]          cap_idx_d, cap_idx_q;
    logic                      abort;
    logic [LINE_BITS-1:0]      line;

    // Address bits above the backing-memory width do not reach the memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_req_addr[31:BMEM_ADDR_BITS];

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        bmem_addr_d = bmem_addr_q;
        bmem_en_d   = bmem_en_q;
        ready_d     = 1'b0;
        lat_cnt_d   = lat_cnt_q;
        blk_d       = blk_q;
        cap_en_d    = 1'b0;
        cap_idx_d   = cap_idx_q;
        abort       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bmem_en_d = 1'b0;
                if (bus.mem_req_valid) begin
                    base_d = bus.mem_req_addr[BMEM_ADDR_BITS-1:0] & ~OFF_MASK;
                    blk_d  = '0;
                    if (LATENCY > 0) begin
                        state_d   = ST_WAIT;
                        lat_cnt_d = LAT_W'(LATENCY);
                    end else begin
                        state_d     = ST_FETCH;
                        bmem_en_d   = 1'b1;
                        bmem_addr_d = base_d;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.mem_req_valid) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (lat_cnt_q == LAT_W'(1)) begin
                    state_d     = ST_FETCH;
                    bmem_en_d   = 1'b1;
                    bmem_addr_d = base_q;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_FETCH: begin
                if (!bus.mem_req_valid) begin
                    abort     = 1'b1;
                    state_d   = ST_IDLE;
                    bmem_en_d = 1'b0;
                end else if (bmem_en_q) begin
                    // Data for this issue arrives next cycle and is written
                    // into its slot at the end of that cycle.
                    cap_en_d  = 1'b1;
                    cap_idx_d = blk_q;
                    if (blk_q == IDX_W'(NUM_BLOCKS - 1)) begin
                        bmem_en_d = 1'b0;
                    end else begin
                        blk_d       = blk_q + IDX_W'(1);
                        bmem_addr_d = bmem_addr_q + BMEM_ADDR_BITS'(4);
                    end
                end else begin
                    // Last word is being captured this cycle.
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            bmem_addr_q <= '0;
            bmem_en_q   <= 1'b0;
            ready_q     <= 1'b0;
            lat_cnt_q   <= '0;
            blk_q       <= '0;
            cap_en_q    <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            bmem_addr_q <= bmem_addr_d;
            bmem_en_q   <= bmem_en_d;
            ready_q     <= ready_d;
            lat_cnt_q   <= lat_cnt_d;
            blk_q       <= blk_d;
            cap_en_q    <= cap_en_d;
            cap_idx_q   <= cap_idx_d;
        end
    end

    icache_line_responder_line_fill_buffer #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_line_fill_buffer (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en_q),
        .cap_idx  (cap_idx_q),
        .cap_data (bus.bmem_rdata),
        .line     (line)
    );

    assign bus.mem_req_ready = ready_q;
    assign bus.mem_req_rdata = line;
    assign bus.bmem_en       = bmem_en_q;
    assign bus.bmem_addr     = bmem_addr_q;

`ifdef ICACHE_RESP_STATS_EN
    logic [31:0] stat_fills_d, stat_fills_q;
    logic [31:0] stat_aborts_d, stat_aborts_q;

    always_comb begin
        stat_fills_d  = stat_fills_q;
        stat_aborts_d = stat_aborts_q;
        if (ready_q && (stat_fills_q != '1))  stat_fills_d  = stat_fills_q + 32'd1;
        if (abort && (stat_aborts_q != '1))   stat_aborts_d = stat_aborts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fills_q  <= '0;
            stat_aborts_q <= '0;
        end else begin
            stat_fills_q  <= stat_fills_d;
            stat_aborts_q <= stat_aborts_d;
        end
    end

    assign stat_fills  = stat_fills_q;
    assign stat_aborts = stat_aborts_q;
`endif

endmodule

// File: tb/tb_icache_line_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_line_responder
// Two responders (LATENCY=2 and LATENCY=0, NUM_BLOCKS=4, 16-bit backing
// address) each with its own behavioural backing memory whose word at byte
// address a is a ^ salt. Expected timing and line content come from the
// cycle rules: reads in cycles L+1..L+N, ready in cycle L+N+2.
// ----------------------------------------------------------------------------
module tb_icache_line_responder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] salt;
    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    int          exp_fills [2];
    int          exp_aborts[2];

    icache_line_responder_if #(.NUM_BLOCKS(N), .BMEM_ADDR_BITS(16)) bus0 ();
    icache_line_responder_if #(.NUM_BLOCKS(N), .BMEM_ADDR_BITS(16)) bus1 ();

    function automatic logic [31:0] mem_word(input logic [15:0] a, input logic [31:0] s);
        return {16'h0, a} ^ s;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    logic [31:0] mem_rdata0 = '0;
    logic [31:0] mem_rdata1 = '0;
    always @(posedge clk) if (bus0.bmem_en) mem_rdata0 <= mem_word(bus0.bmem_addr, salt);
    always @(posedge clk) if (bus1.bmem_en) mem_rdata1 <= mem_word(bus1.bmem_addr, salt);

    assign bus0.mem_req_valid = req_valid[0];
    assign bus0.mem_req_addr  = req_addr[0];
    assign bus0.bmem_rdata    = mem_rdata0;
    assign bus1.mem_req_valid = req_valid[1];
    assign bus1.mem_req_addr  = req_addr[1];
    assign bus1.bmem_rdata    = mem_rdata1;

    wire         obs_ready [2];
    wire         obs_en    [2];
    wire [15:0]  obs_addr  [2];
    wire [127:0] obs_rdata [2];
    assign obs_ready[0] = bus0.mem_req_ready;
    assign obs_ready[1] = bus1.mem_req_ready;
    assign obs_en[0]    = bus0.bmem_en;
    assign obs_en[1]    = bus1.bmem_en;
    assign obs_addr[0]  = bus0.bmem_addr;
    assign obs_addr[1]  = bus1.bmem_addr;
    assign obs_rdata[0] = bus0.mem_req_rdata;
    assign obs_rdata[1] = bus1.mem_req_rdata;

`ifdef ICACHE_RESP_STATS_EN
    wire [31:0] st_fills0, st_fills1, st_aborts0, st_aborts1;
`endif

    icache_line_responder #(
        .BLOCK_SIZE(4), .NUM_BLOCKS(N), .LATENCY(2), .BMEM_ADDR_BITS(16)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
`ifdef ICACHE_RESP_STATS_EN
        , .stat_fills(st_fills0), .stat_aborts(st_aborts0)
`endif
    );

    icache_line_responder #(
        .BLOCK_SIZE(4), .NUM_BLOCKS(N), .LATENCY(0), .BMEM_ADDR_BITS(16)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
`ifdef ICACHE_RESP_STATS_EN
        , .stat_fills(st_fills1), .stat_aborts(st_aborts1)
`endif
    );

    // One request on responder d, starting at posedge+1 of cycle 0 and
    // returning at posedge+1 of cycle L+N+4. abort_at<0 means no abort.
    task automatic run_fill(input int d, input logic [31:0] addr, input int abort_at,
                            output logic [127:0] line_seen);
        int           L;
        logic [31:0]  base;
        logic [15:0]  wa;
        logic [127:0] exp_line;
        logic         aborted, exp_en, exp_rdy;
        L         = lat_of(d);
        base      = addr & ~32'(N * 4 - 1);
        line_seen = '0;
        for (int k = 0; k < N; k++) begin
            wa = 16'(base + 32'(4 * k));
            exp_line[k*32 +: 32] = mem_word(wa, salt);
        end
        for (int c = 0; c <= L + N + 3; c++) begin
            if (c == 0) begin
                req_valid[d] = 1'b1;
                req_addr[d]  = addr;
            end else begin
                req_addr[d] = $urandom;
            end
            if (c == abort_at || c == L + N + 3) req_valid[d] = 1'b0;
            @(negedge clk);
            aborted = (abort_at >= 0) && (c > abort_at);
            exp_en  = !aborted && (c >= L + 1) && (c <= L + N);
            exp_rdy = (abort_at < 0) && (c == L + N + 2);
            vectors++;
            if (obs_en[d] !== exp_en) begin
                miscompares++;
                $display("FAIL bmem_en dut%0d cycle %0d: got %b want %b", d, c, obs_en[d], exp_en);
            end
            if (exp_en) begin
                wa = 16'(base + 32'(4 * (c - L - 1)));
                vectors++;
                if (obs_addr[d] !== wa) begin
                    miscompares++;
                    $display("FAIL bmem_addr dut%0d cycle %0d: got %h want %h", d, c, obs_addr[d], wa);
                end
            end
            vectors++;
            if (obs_ready[d] !== exp_rdy) begin
                miscompares++;
                $display("FAIL ready dut%0d cycle %0d: got %b want %b", d, c, obs_ready[d], exp_rdy);
            end
            if ((abort_at < 0) && (c >= L + N + 2)) begin
                vectors++;
                if (obs_rdata[d] !== exp_line) begin
                    miscompares++;
                    $display("FAIL rdata dut%0d cycle %0d: got %h want %h", d, c, obs_rdata[d], exp_line);
                end
            end
            if (c == L + N + 2) line_seen = obs_rdata[d];
            @(posedge clk); #1;
        end
        if (abort_at < 0) exp_fills[d]++;
        else              exp_aborts[d]++;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_addr[0] = '0;    req_addr[1] = '0;
        exp_fills[0] = 0; exp_fills[1] = 0; exp_aborts[0] = 0; exp_aborts[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({obs_ready[d], obs_en[d], obs_addr[d], obs_rdata[d]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b en=%b addr=%h rdata=%h want all 0",
                         d, obs_ready[d], obs_en[d], obs_addr[d], obs_rdata[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_single_fill();
        logic [127:0] line;
        logic [127:0] want;
        want = 128'h0000123C_00001238_00001234_00001230;
        salt = '0;
        run_fill(0, 32'h0000_1234, -1, line);
        vectors++;
        if (line !== want) begin
            miscompares++;
            $display("FAIL single_fill_line: got %h want %h", line, want);
        end
        idle_cycles(2);
    endtask

    task automatic test_zero_latency();
        logic [127:0] line;
        salt = $urandom;
        run_fill(1, $urandom, -1, line);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        logic [127:0] line;
        salt = $urandom;
        for (int d = 0; d < 2; d++) begin
            run_fill(d, $urandom, -1, line);
            run_fill(d, $urandom, -1, line);
        end
        idle_cycles(1);
    endtask

    task automatic test_abort();
        logic [127:0] line;
        salt = $urandom;
        run_fill(0, $urandom, 4, line);
        run_fill(0, $urandom, -1, line);
        run_fill(1, $urandom, 2, line);
        run_fill(1, $urandom, -1, line);
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_fill();
        logic [127:0] line;
        salt = $urandom;
        req_valid[0] = 1'b1;
        req_addr[0]  = $urandom;
        idle_cycles(4);          // now in cycle 4, FETCH for L=2
        reset = 1'b1;
        req_valid[0] = 1'b0;
        idle_cycles(1);
        @(negedge clk);
        vectors++;
        if ({obs_ready[0], obs_en[0], obs_addr[0], obs_rdata[0]} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_fill: got rdy=%b en=%b addr=%h rdata=%h want all 0",
                     obs_ready[0], obs_en[0], obs_addr[0], obs_rdata[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_fills[0] = 0; exp_fills[1] = 0; exp_aborts[0] = 0; exp_aborts[1] = 0;
        run_fill(0, $urandom, -1, line);
        idle_cycles(1);
    endtask

    task automatic test_addr_wrap();
        logic [127:0] line;
        logic [127:0] want;
        want = 128'h0000FFFC_0000FFF8_0000FFF4_0000FFF0;
        salt = '0;
        run_fill(0, 32'h0001_FFF0, -1, line);
        vectors++;
        if (line !== want) begin
            miscompares++;
            $display("FAIL addr_wrap_line: got %h want %h", line, want);
        end
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic [127:0] line;
        int d, ab;
        for (int i = 0; i < 24; i++) begin
            d    = int'($urandom_range(0, 1));
            salt = $urandom;
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat_of(d) + N + 1)) : -1;
            run_fill(d, $urandom, ab, line);
            idle_cycles(int'($urandom_range(0, 3)));
        end
    endtask

`ifdef ICACHE_RESP_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        vectors += 4;
        if (st_fills0 !== 32'(exp_fills[0])) begin
            miscompares++; $display("FAIL stat_fills dut0: got %0d want %0d", st_fills0, exp_fills[0]);
        end
        if (st_aborts0 !== 32'(exp_aborts[0])) begin
            miscompares++; $display("FAIL stat_aborts dut0: got %0d want %0d", st_aborts0, exp_aborts[0]);
        end
        if (st_fills1 !== 32'(exp_fills[1])) begin
            miscompares++; $display("FAIL stat_fills dut1: got %0d want %0d", st_fills1, exp_fills[1]);
        end
        if (st_aborts1 !== 32'(exp_aborts[1])) begin
            miscompares++; $display("FAIL stat_aborts dut1: got %0d want %0d", st_aborts1, exp_aborts[1]);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        salt = '0;
        test_reset();
        test_single_fill();
        test_zero_latency();
        test_back_to_back();
        test_reset_mid_fill();
        test_abort();
`ifdef ICACHE_RESP_STATS_EN
        test_stats();
`endif
        test_addr_wrap();
        test_random();
`ifdef ICACHE_RESP_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_line_responder.md
Name: icache_line_responder

Overview:
- Memory-side responder for the instruction cache's line-fill request interface.
- Accepts a line request (valid/addr), waits a programmable latency, then reads NUM_BLOCKS consecutive 32-bit words from a word-wide synchronous backing memory.
- Assembles the words into one wide line and returns it with a single-cycle ready pulse.
- Sits between the icache and the SoC ROM/SRAM, or acts as the bench memory model.

Parameters:
- BLOCK_SIZE, 4: bytes per block (word); fixed at 4, 32-bit words.
- NUM_BLOCKS, 4: words per line; power of two, ≥2.
- LATENCY, 2: wait cycles inserted before the first backing read; 0 allowed.
- BMEM_ADDR_BITS, 16: byte-address width presented to backing memory.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_req_valid  in  1  line request; held high by the cache until ready is seen or the request is abandoned
- mem_req_ready  out  1  one-cycle pulse; line data valid this cycle
- mem_req_addr  in  32  line address; low log2(NUM_BLOCKS)+2 bits ignored
- mem_req_rdata  out  8*BLOCK_SIZE*NUM_BLOCKS  assembled line; word k at bits [k*32 +: 32]
- bmem_en  out  1  backing read enable
- bmem_addr  out  BMEM_ADDR_BITS  backing byte address, word aligned
- bmem_rdata  in  32  backing data, valid the cycle after bmem_en

Behaviour:
- Reset (synchronous, active-high, clk): all outputs cleared.
  - mem_req_ready=0, mem_req_rdata=0, bmem_en=0, bmem_addr=0.
  - State=IDLE, counters=0.
- FSM states: IDLE, WAIT, FETCH, RESP.
- IDLE:
  - On a sampled mem_req_valid=1, latch base = addr with the offset bits zeroed.
  - Go to WAIT if LATENCY>0, else FETCH.
  - Cycle 0 is defined as the cycle valid is first sampled in IDLE.
- WAIT: countdown LATENCY cycles (cycles 1..L), then FETCH.
- FETCH: lasts NUM_BLOCKS+1 cycles.
  - Cycles L+1..L+N: bmem_en=1, bmem_addr = base + 4*k, for k=0..N-1.
  - Each returned word is captured into line slot k on the edge after its issue cycle; the last capture falls in cycle L+N+1, when bmem_en=0.
  - Then go to RESP.
- RESP: mem_req_ready=1 for exactly cycle L+N+2; mem_req_rdata holds the complete line. Next state is IDLE unconditionally.
  - The valid still high on the RESP edge is not treated as a new request.
  - The cache drops valid one cycle later.
- Total latency from cycle 0 to ready: L+N+2 (L=2, N=4 → cycle 8; L=0, N=4 → cycle 6).
- mem_req_rdata holds its value after RESP until overwritten by the next fill's word captures.
- Abort: mem_req_valid sampled 0 in WAIT or FETCH → IDLE on the next edge.
  - No ready pulse; bmem_en deasserts.
  - In-flight backing data is discarded; the partial line content is don't-care.
- mem_req_addr changes while busy are ignored; only the address latched at cycle 0 is used.
- bmem_addr is formed from the low BMEM_ADDR_BITS of base + 4*k; the address wraps modulo 2^BMEM_ADDR_BITS, with no error.
- Reset asserted mid-fill: immediate return to the reset state; no ready pulse.
- Never more than one outstanding request; mem_req_ready is never high on two consecutive cycles.

Optional Feature:
- Macro: ICACHE_RESP_STATS_EN.
- When defined, adds outputs stat_fills[31:0] and stat_aborts[31:0], both reset to 0.
  - stat_fills increments on each ready pulse.
  - stat_aborts increments on each abort transition.
  - Both saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - state enum (IDLE/WAIT/FETCH/RESP);
  - WORD_BITS=32;
  - BYTE_OFFSET_BITS=2;
  - line-offset width function log2(NUM_BLOCKS).
- One natural sub-module: line_fill_buffer, which takes the slot index, a capture strobe and 32-bit data and holds the wide line register.
- The top level keeps the FSM, latency counter and address generation.

Test Plan:
- Single fill, L=2, N=4, addr=0x0000_1234, backing word[a]=a: base=0x1230, bmem_addr 0x1230/34/38/3C in cycles 3–6, ready only in cycle 8, rdata={0x123C,0x1238,0x1234,0x1230}.
- L=0: valid at cycle 0 → bmem_en in cycles 1–4, ready in cycle 6; valid held through the ready edge does not start a second fill (bmem_en stays 0 in cycle 7).
- Back-to-back: second request raised two cycles after ready → second fill completes with correct data and its own ready pulse at +8 cycles.
- Abort: valid dropped in cycle 4 of a fill → bmem_en=0 by cycle 5, no ready pulse, next request served normally; with ICACHE_RESP_STATS_EN, stat_aborts=1 and stat_fills=1.
- Reset asserted during FETCH → the cycle after, all outputs are 0 and state is IDLE; a subsequent request completes with correct latency.
- Address wrap: BMEM_ADDR_BITS=16, addr=0x0001_FFF0 → bmem_addr 0xFFF0..0xFFFC, line assembled correctly.
